uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- UART transmitter: 8 data bits, 1 start bit, 1 stop bit, no parity, LSB first, line idles high.
- A small byte FIFO sits in front of the serializer, so the sensor/host-side logic can queue several bytes without waiting on the line.
- Pairs with the on-chip UART receiver. Uses the same bit period: 217 clocks/bit, e.g. 25 MHz clock at 115200 baud.

Parameters:
- CLKS_PER_BIT, 217, i_CLK cycles per serial bit. Legal range 4..255; the bit counter is 8 bits.
- FIFO_DEPTH, 4, byte entries. Must be a power of 2, at least 2.
- ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
- i_CLK  input  1  system clock.
- w_rst  input  1  reset: asynchronous, active-high.
- i_Tx_DV  input  1  write strobe; byte accepted on a rising edge when o_Tx_Ready=1.
- i_Tx_Byte  input  8  byte to queue.
- o_Tx_Ready  output  1  FIFO not full.
- o_Tx_Overflow  output  1  one-cycle pulse when i_Tx_DV=1 while FIFO is full; the byte is dropped.
- o_Tx_Serial  output  1  serial line, registered.
- o_Tx_Active  output  1  high while a frame (start, data, stop) is on the line.
- o_Tx_Done  output  1  one-cycle pulse after each stop bit completes.
- o_Fifo_Count  output  ADDR_W+1  number of queued bytes (0..FIFO_DEPTH).

Behaviour:
- Reset values (async): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Overflow=0, o_Fifo_Count=0, o_Tx_Ready=1; FIFO pointers 0, state IDLE, bit counter 0, bit index 0.
- FIFO write: push when i_Tx_DV && o_Tx_Ready.
  - o_Tx_Ready = (count != FIFO_DEPTH), combinational from the registered count.
  - Full + i_Tx_DV: no write, o_Tx_Overflow=1 on the next cycle only.
- FIFO pop: happens only in IDLE when count != 0. The head byte loads into the shift register.
- Simultaneous push and pop: count unchanged. If the FIFO was full, the push is still refused, because ready reflects the pre-edge count.
- Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH and never underflows.
- State machine, one register encoding:
  - IDLE: line=1, Active=0. If count!=0: pop, clear counter and bit index, go to START.
  - START: line=0 for exactly CLKS_PER_BIT cycles. Counter runs 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 clear it and go to DATA.
  - DATA: line = shift_reg[bit_index] for CLKS_PER_BIT cycles per bit, bit_index 0..7. After bit 7 completes, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. Then go to CLEANUP with o_Tx_Done=1.
  - CLEANUP: one cycle, Active=0, line=1, Done=1 during this cycle only. Then go to IDLE.
  - Illegal state: go to IDLE, line=1.
- o_Tx_Active is high in START, DATA and STOP only.
- Latency: a byte written into an empty FIFO at edge T is popped at edge T+1. The start bit appears on o_Tx_Serial after edge T+2, because o_Tx_Serial is registered.
- Back-to-back frames: start-bit falling edges are exactly 10*CLKS_PER_BIT+2 cycles apart (CLEANUP plus the IDLE pop cycle).
- i_Tx_Byte changing after acceptance has no effect on the frame.
- Reset mid-frame: the line returns high immediately and the FIFO is emptied. The aborted byte and all queued bytes are lost.

Test Plan:
- Single byte 0xA5 into an idle block (CLKS_PER_BIT=217) -> line low 217 cycles, then bits 1,0,1,0,0,1,0,1 at 217 cycles each, stop high 217 cycles. o_Tx_Done pulses once; o_Tx_Active is high for exactly 2170 cycles.
- Five consecutive i_Tx_DV cycles (0x01..0x05) while idle -> o_Fifo_Count peaks at 4 (byte 0x01 already popped). 0x05 is accepted, giving 0x01..0x05 all sent, with start edges 2172 cycles apart. Repeat with the serializer busy -> the fifth write is refused and o_Tx_Overflow pulses once.
- Write while full on the same cycle as an IDLE pop -> write refused, o_Fifo_Count goes 4->3, o_Tx_Overflow=1.
- Loopback of o_Tx_Serial into the UART receiver, bytes 0x00, 0xFF, 0x55, 0x80 -> receiver o_Rx_Byte matches each, with one o_Rx_DV pulse per byte.
- Assert w_rst during DATA bit 3 with 2 bytes queued -> o_Tx_Serial=1 and o_Fifo_Count=0 asynchronously. After release, no frame is sent until a new write.
- CLKS_PER_BIT=4 smoke run, byte 0x3C -> frame is 40 cycles, LSB first.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter (LSB first, idle high) fed from a small byte FIFO.
// Line, Active and Done are registered from the serializer state, so all three trail it by one cycle.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic              i_CLK,
  input  logic              w_rst,
  input  logic              i_Tx_DV,
  input  logic [7:0]        i_Tx_Byte,
  output logic              o_Tx_Ready,
  output logic              o_Tx_Overflow,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done,
  output logic [ADDR_W:0]   o_Fifo_Count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  localparam logic [7:0]        CNT_MAX    = 8'(CLKS_PER_BIT) - 8'd1;
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1'b1);

  logic [7:0]        fifo_mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [7:0]        clk_cnt_r;
  logic [7:0]        clk_cnt_nxt_s;
  logic [2:0]        bit_idx_r;
  logic [2:0]        bit_idx_nxt_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_nxt_s;
  logic              line_s;
  logic              serial_r;
  logic              active_r;
  logic              done_r;

  logic              push_s;
  logic              pop_s;

  // Ready uses the pre-edge count, so a push on a full FIFO is refused even if a pop happens on the same edge
  assign o_Tx_Ready    = (count_r != COUNT_FULL);
  assign push_s        = i_Tx_DV && o_Tx_Ready;
  assign pop_s         = (state_r == IDLE) && (count_r != COUNT_ZERO);
  assign o_Fifo_Count  = count_r;
  assign o_Tx_Overflow = overflow_r;
  assign o_Tx_Serial   = serial_r;
  assign o_Tx_Active   = active_r;
  assign o_Tx_Done     = done_r;

  // FIFO storage, pointers, occupancy and overflow flag
  always_ff @(posedge i_CLK or posedge w_rst) begin
    if (w_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= COUNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= i_Tx_DV && !o_Tx_Ready;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= i_Tx_Byte;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer next-state logic and current line level
  always_comb begin
    state_nxt_s   = state_r;
    clk_cnt_nxt_s = clk_cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    line_s        = 1'b1;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          shift_nxt_s   = fifo_mem_r[rd_ptr_r];
          clk_cnt_nxt_s = 8'd0;
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = START;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      START: begin
        line_s = 1'b0;
        if (clk_cnt_r == CNT_MAX) begin
          clk_cnt_nxt_s = 8'd0;
          state_nxt_s   = DATA;
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 8'd1;
        end
      end
      DATA: begin
        line_s = shift_r[bit_idx_r];
        if (clk_cnt_r == CNT_MAX) begin
          clk_cnt_nxt_s = 8'd0;
          if (bit_idx_r == 3'd7) begin
            bit_idx_nxt_s = 3'd0;
            state_nxt_s   = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 8'd1;
        end
      end
      STOP: begin
        if (clk_cnt_r == CNT_MAX) begin
          clk_cnt_nxt_s = 8'd0;
          state_nxt_s   = CLEANUP;
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 8'd1;
        end
      end
      CLEANUP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        line_s      = 1'b1;
      end
    endcase
  end

  // Serializer state and registered line/status outputs
  always_ff @(posedge i_CLK or posedge w_rst) begin
    if (w_rst) begin
      state_r   <= IDLE;
      clk_cnt_r <= 8'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      serial_r  <= 1'b1;
      active_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clk_cnt_r <= clk_cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      serial_r  <= line_s;
      active_r  <= (state_r == START) || (state_r == DATA) || (state_r == STOP);
      done_r    <= (state_r == CLEANUP);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level model checked every cycle, a behavioural loopback
// receiver, and directed scenarios with hand-computed literal expectations.
module tb_uart_tx_buffered;
  localparam int CPB   = 217;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv, dv4;
  logic [7:0] din, din4;
  logic       ready, ovf, ser, act, done;
  logic [2:0] cnt;
  logic       ready4, ovf4, ser4, act4, done4;
  logic [2:0] cnt4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .i_CLK(clk), .w_rst(rst), .i_Tx_DV(dv), .i_Tx_Byte(din),
    .o_Tx_Ready(ready), .o_Tx_Overflow(ovf), .o_Tx_Serial(ser),
    .o_Tx_Active(act), .o_Tx_Done(done), .o_Fifo_Count(cnt));

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .ADDR_W(2)) dut4 (
    .i_CLK(clk), .w_rst(rst), .i_Tx_DV(dv4), .i_Tx_Byte(din4),
    .o_Tx_Ready(ready4), .o_Tx_Overflow(ovf4), .o_Tx_Serial(ser4),
    .o_Tx_Active(act4), .o_Tx_Done(done4), .o_Fifo_Count(cnt4));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0] m_q[$];
  logic [7:0] rxexp_q[$];
  logic [7:0] m_byte = 8'h00;
  int         m_t0 = -100000;
  int         m_next_pop = 0;
  logic       m_ovf = 1'b0;

  function automatic logic exp_line(input int c);
    int off;
    off = c - m_t0;
    if (off < 0 || off >= FRAME) return 1'b1;
    case (off / CPB)
      0:       return 1'b0;
      9:       return 1'b1;
      default: return m_byte[off / CPB - 1];
    endcase
  endfunction

  initial begin : model
    int k, pre;
    logic push, pop;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        rxexp_q.delete();
        m_t0 = -100000;
        m_next_pop = 0;
        m_ovf = 1'b0;
        chk("rst_serial", ser, 1);
        chk("rst_active", act, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count", cnt, 0);
        chk("rst_ready", ready, 1);
      end else begin
        chk("serial", ser, exp_line(cyc));
        chk("active", act, (cyc >= m_t0 && cyc < m_t0 + FRAME));
        chk("done", done, (cyc == m_t0 + FRAME));
        chk("overflow", ovf, m_ovf);
        chk("count", cnt, m_q.size());
        chk("ready", ready, (m_q.size() != DEPTH));
        k    = cyc + 1;
        pre  = m_q.size();
        push = dv && (pre != DEPTH);
        m_ovf = dv && (pre == DEPTH);
        pop  = (pre != 0) && (k >= m_next_pop);
        if (pop) begin
          m_byte = m_q.pop_front();
          m_t0 = k + 1;
          m_next_pop = k + FRAME + 2;
          rxexp_q.push_back(m_byte);
        end
        if (push) m_q.push_back(din);
      end
    end
  end

  // ---------------- loopback receiver ----------------
  logic [7:0] rx_log[$];
  int         start_log[$];

  initial begin : rx
    logic [7:0] b;
    logic stopb, abort;
    forever begin
      do @(negedge clk); while (rst || ser !== 1'b0);
      start_log.push_back(cyc);
      abort = 1'b0;
      b = 8'h00;
      stopb = 1'b0;
      for (int off = 1; off <= 9 * CPB + CPB / 2; off++) begin
        @(negedge clk);
        if (rst) abort = 1'b1;
        if (off % CPB == CPB / 2) begin
          if (off / CPB >= 1 && off / CPB <= 8) b[off / CPB - 1] = ser;
          else if (off / CPB == 9) stopb = ser;
        end
      end
      if (!abort) begin
        rx_log.push_back(b);
        chk("rx_stop", stopb, 1);
        if (rxexp_q.size() == 0) chk("rx_unexpected", b, 32'hFFFF_FFFF);
        else chk("rx_byte", b, rxexp_q.pop_front());
      end
    end
  end

  // ---------------- per-test activity monitor ----------------
  int test_id = 0, mon_id = 0;
  int act_n = 0, done_n = 0, ovf_n = 0, peak = 0;

  always @(negedge clk) begin
    if (test_id != mon_id) begin
      mon_id <= test_id; act_n <= 0; done_n <= 0; ovf_n <= 0; peak <= 0;
    end else begin
      if (act)  act_n  <= act_n + 1;
      if (done) done_n <= done_n + 1;
      if (ovf)  ovf_n  <= ovf_n + 1;
      if (int'(cnt) > peak) peak <= int'(cnt);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] stim_q[$];
  int first_edge;

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_q();
    for (int i = 0; i < stim_q.size(); i++) begin
      dv = 1'b1;
      din = stim_q[i];
      @(posedge clk); #1;
      if (i == 0) first_edge = cyc;
    end
    dv = 1'b0;
    din = 8'hEE;
    stim_q.delete();
  endtask

  initial begin : stim
    int base, nstart, ndone, tries;
    logic [9:0] fr4;
    rst = 1'b1; dv = 1'b0; din = 8'h00; dv4 = 1'b0; din4 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("init_serial", ser, 1);
    chk("init_count", cnt, 0);
    chk("init_ready", ready, 1);
    #1 rst = 1'b0;
    wait_n(3);

    // single byte 0xA5
    test_id = 1; wait_n(2);
    base = start_log.size();
    stim_q = '{8'hA5}; send_q();
    wait_n(FRAME + 30);
    chk("a5_active_cycles", act_n, 32'd2170);
    chk("a5_done_pulses", done_n, 32'd1);
    chk("a5_rx", rx_log[rx_log.size() - 1], 32'hA5);
    chk("a5_latency", start_log[base] - first_edge, 32'd2);

    // five writes while idle
    test_id = 2; wait_n(2);
    base = start_log.size();
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; send_q();
    wait_n(5 * (FRAME + 2) + 50);
    chk("burst_peak", peak, 32'd4);
    chk("burst_ovf", ovf_n, 32'd0);
    chk("burst_done", done_n, 32'd5);
    for (int i = 0; i < 5; i++) chk("burst_rx", rx_log[rx_log.size() - 5 + i], i + 1);
    for (int i = 1; i < 5; i++) chk("burst_spacing", start_log[base + i] - start_log[base + i - 1], 32'd2172);

    // five writes while busy, then a write while full on the pop edge
    test_id = 3; wait_n(2);
    stim_q = '{8'h10}; send_q();
    wait_n(20);
    stim_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; send_q();
    wait_n(2);
    chk("busy_peak", peak, 32'd4);
    chk("busy_ovf", ovf_n, 32'd1);
    tries = 0;
    while (cyc != m_next_pop - 1 && tries < 3000) begin
      @(posedge clk); #1; tries++;
    end
    chk("full_pop_reached", (tries < 3000), 1);
    dv = 1'b1; din = 8'h16;
    @(posedge clk); #1;
    dv = 1'b0; din = 8'hEE;
    chk("full_pop_count", cnt, 32'd3);
    chk("full_pop_ovf", ovf, 32'd1);
    wait_n(4 * (FRAME + 2) + 300);
    chk("busy_ovf_total", ovf_n, 32'd2);
    for (int i = 0; i < 5; i++) chk("busy_rx", rx_log[rx_log.size() - 5 + i], 32'h10 + i);

    // loopback patterns
    test_id = 4; wait_n(2);
    stim_q = '{8'h00, 8'hFF, 8'h55, 8'h80}; send_q();
    wait_n(4 * (FRAME + 2) + 300);
    chk("lb_done", done_n, 32'd4);
    chk("lb_rx0", rx_log[rx_log.size() - 4], 32'h00);
    chk("lb_rx1", rx_log[rx_log.size() - 3], 32'hFF);
    chk("lb_rx2", rx_log[rx_log.size() - 2], 32'h55);
    chk("lb_rx3", rx_log[rx_log.size() - 1], 32'h80);

    // reset during data bit 3 with two bytes queued
    test_id = 5; wait_n(2);
    stim_q = '{8'hAA, 8'hBB, 8'hCC}; send_q();
    tries = 0;
    while (cyc != m_t0 + 4 * CPB + CPB / 2 && tries < 2000) begin
      @(posedge clk); #1; tries++;
    end
    chk("rst_mid_reached", (tries < 2000), 1);
    chk("rst_mid_queued", cnt, 32'd2);
    chk("rst_mid_bit3", ser, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_serial", ser, 32'd1);
    chk("rst_mid_count", cnt, 32'd0);
    chk("rst_mid_ready", ready, 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    nstart = start_log.size();
    ndone = done_n;
    wait_n(3000);
    chk("post_rst_no_frame", start_log.size(), nstart);
    chk("post_rst_no_done", done_n, ndone);
    stim_q = '{8'h42}; send_q();
    wait_n(FRAME + 300);
    chk("post_rst_rx", rx_log[rx_log.size() - 1], 32'h42);

    // CLKS_PER_BIT=4 smoke run
    fr4 = {1'b1, 8'h3C, 1'b0};
    dv4 = 1'b1; din4 = 8'h3C;
    @(posedge clk); #1;
    first_edge = cyc;
    dv4 = 1'b0; din4 = 8'h00;
    tries = 0;
    do begin @(negedge clk); tries++; end while (ser4 !== 1'b0 && tries < 20);
    chk("smoke_start_found", (tries < 20), 1);
    chk("smoke_latency", cyc - first_edge, 32'd2);
    for (int i = 0; i < 40; i++) begin
      chk("smoke_line", ser4, fr4[i / 4]);
      chk("smoke_active", act4, 1);
      @(negedge clk);
    end
    chk("smoke_end_active", act4, 0);
    chk("smoke_end_serial", ser4, 1);
    chk("smoke_end_done", done4, 1);
    wait_n(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
